// File: rtl/wb_trace_buffer.sv
// Writeback commit-trace FIFO: records every register-writing commit with a cycle stamp.
// Optional macro WB_TRACE_HILO_EN adds HI/LO capture per entry; otherwise TraceHi/TraceLo are 0.
module wb_trace_buffer #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int STAMP_W = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                MEMWB_RegWrite,
    input  logic [31:0]         MEMWB_DataResult,
    input  logic [31:0]         PCResult,
    input  logic [31:0]         ALUhi,
    input  logic [31:0]         ALUlo,
    input  logic                TraceReady,
    output logic                TraceValid,
    output logic [31:0]         TracePC,
    output logic [31:0]         TraceData,
    output logic [31:0]         TraceHi,
    output logic [31:0]         TraceLo,
    output logic [STAMP_W-1:0]  TraceStamp,
    output logic [ADDR_W:0]     TraceCount,
    output logic                Overflow,
    output logic [7:0]          DropCount
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [STAMP_W-1:0] stamp_q;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_q, drop_d;

    logic [31:0]        pc_mem    [DEPTH];
    logic [31:0]        data_mem  [DEPTH];
    logic [STAMP_W-1:0] stamp_mem [DEPTH];

    logic valid, full, push, pop, drop;

    // Handshake: an entry transfers on any edge where TraceValid && TraceReady;
    // while TraceValid is high and TraceReady low the head is held unchanged.
    assign valid = (count_q != '0);
    assign full  = (count_q == FULL_CNT);
    assign pop   = valid & TraceReady;
    assign push  = MEMWB_RegWrite & (~full | pop);
    assign drop  = MEMWB_RegWrite & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        drop_d     = drop_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push && !pop) count_d = count_q + CNT_ONE;
        if (pop && !push) count_d = count_q - CNT_ONE;
        if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stamp_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stamp_q    <= stamp_q + STAMP_W'(1);
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage is not reset; outputs are gated by TraceValid so stale contents never show.
    always_ff @(posedge Clk) begin
        if (push && !Reset) begin
            pc_mem[wr_ptr_q]    <= PCResult;
            data_mem[wr_ptr_q]  <= MEMWB_DataResult;
            stamp_mem[wr_ptr_q] <= stamp_q;
        end
    end

    assign TraceValid = valid;
    assign TracePC    = valid ? pc_mem[rd_ptr_q]    : '0;
    assign TraceData  = valid ? data_mem[rd_ptr_q]  : '0;
    assign TraceStamp = valid ? stamp_mem[rd_ptr_q] : '0;
    assign TraceCount = count_q;
    assign Overflow   = overflow_q;
    assign DropCount  = drop_q;

`ifdef WB_TRACE_HILO_EN
    logic [31:0] hi_mem [DEPTH];
    logic [31:0] lo_mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (push && !Reset) begin
            hi_mem[wr_ptr_q] <= ALUhi;
            lo_mem[wr_ptr_q] <= ALUlo;
        end
    end

    assign TraceHi = valid ? hi_mem[rd_ptr_q] : '0;
    assign TraceLo = valid ? lo_mem[rd_ptr_q] : '0;
`else
    logic unused_hilo;
    assign unused_hilo = ^{ALUhi, ALUlo};
    assign TraceHi = '0;
    assign TraceLo = '0;
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: reset, single commit, fill/overflow, full push+pop,
// drop saturation, reset mid-drain and stamp wrap with HI/LO (WB_TRACE_HILO_EN aware).
module tb_wb_trace_buffer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MEMWB_RegWrite;
    logic [31:0] MEMWB_DataResult;
    logic [31:0] PCResult;
    logic [31:0] ALUhi;
    logic [31:0] ALUlo;
    logic        TraceReady;
    logic        TraceValid;
    logic [31:0] TracePC;
    logic [31:0] TraceData;
    logic [31:0] TraceHi;
    logic [31:0] TraceLo;
    logic [15:0] TraceStamp;
    logic [4:0]  TraceCount;
    logic        Overflow;
    logic [7:0]  DropCount;

    int checks = 0;
    int errors = 0;

`ifdef WB_TRACE_HILO_EN
    localparam bit HILO = 1'b1;
`else
    localparam bit HILO = 1'b0;
`endif

    wb_trace_buffer #(.DEPTH(16), .ADDR_W(4), .STAMP_W(16)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .MEMWB_RegWrite   (MEMWB_RegWrite),
        .MEMWB_DataResult (MEMWB_DataResult),
        .PCResult         (PCResult),
        .ALUhi            (ALUhi),
        .ALUlo            (ALUlo),
        .TraceReady       (TraceReady),
        .TraceValid       (TraceValid),
        .TracePC          (TracePC),
        .TraceData        (TraceData),
        .TraceHi          (TraceHi),
        .TraceLo          (TraceLo),
        .TraceStamp       (TraceStamp),
        .TraceCount       (TraceCount),
        .Overflow         (Overflow),
        .DropCount        (DropCount)
    );

    // clock/reset block
    always #5 Clk = ~Clk;

    // advance one edge; inputs change and outputs are sampled 1 time unit later
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] data);
        MEMWB_RegWrite   = 1'b1;
        PCResult         = pc;
        MEMWB_DataResult = data;
    endtask

    task automatic idle_inputs();
        MEMWB_RegWrite   = 1'b0;
        PCResult         = 'x;
        MEMWB_DataResult = 'x;
        ALUhi            = 'x;
        ALUlo            = 'x;
    endtask

    logic [31:0] drain_exp [16];

    initial begin
        // reset then idle
        Reset = 1'b1;
        TraceReady = 1'b0;
        idle_inputs();
        step();
        step();
        Reset = 1'b0;
        check("rst_valid", 32'(TraceValid), 32'd0);
        check("rst_count", 32'(TraceCount), 32'd0);
        check("rst_ovf",   32'(Overflow),   32'd0);
        check("rst_drop",  32'(DropCount),  32'd0);
        check("rst_pc",    TracePC,         32'd0);
        step();
        step();
        step();

        // single commit in the cycle where stamp = 3
        commit(32'h0000_0004, 32'h0000_00AB);
        ALUhi = 32'h1111_1111;
        ALUlo = 32'h2222_2222;
        step();
        idle_inputs();
        check("one_valid", 32'(TraceValid), 32'd1);
        check("one_pc",    TracePC,         32'h4);
        check("one_data",  TraceData,       32'hAB);
        check("one_count", 32'(TraceCount), 32'd1);
        check("one_stamp", 32'(TraceStamp), 32'd3);
        check("one_hi",    TraceHi, HILO ? 32'h1111_1111 : 32'd0);
        check("one_lo",    TraceLo, HILO ? 32'h2222_2222 : 32'd0);
        step();
        step();
        step();
        check("hold_data",  TraceData,       32'hAB);
        check("hold_stamp", 32'(TraceStamp), 32'd3);
        check("hold_count", 32'(TraceCount), 32'd1);

        // push and pop together at occupancy 1 (stamp = 7 in this cycle)
        commit(32'h0000_0008, 32'h0000_0055);
        TraceReady = 1'b1;
        step();
        idle_inputs();
        check("pp1_count", 32'(TraceCount), 32'd1);
        check("pp1_data",  TraceData,       32'h55);
        check("pp1_stamp", 32'(TraceStamp), 32'd7);
        step();
        TraceReady = 1'b0;
        check("pop_valid", 32'(TraceValid), 32'd0);
        check("pop_count", 32'(TraceCount), 32'd0);
        TraceReady = 1'b1;
        step();
        TraceReady = 1'b0;
        check("empty_rdy_count", 32'(TraceCount), 32'd0);

        // fill and overflow: 20 commits, data 1..20
        for (int i = 1; i <= 20; i++) begin
            commit(32'(i * 4), 32'(i));
            step();
        end
        idle_inputs();
        check("fill_count", 32'(TraceCount), 32'd16);
        check("fill_ovf",   32'(Overflow),   32'd1);
        check("fill_drop",  32'(DropCount),  32'd4);
        check("fill_head",  TraceData,       32'd1);
        check("fill_pc",    TracePC,         32'd4);

        // full FIFO push + pop: no drop, new entry goes to the tail
        commit(32'h0000_0190, 32'd100);
        TraceReady = 1'b1;
        step();
        idle_inputs();
        TraceReady = 1'b0;
        check("fpp_count", 32'(TraceCount), 32'd16);
        check("fpp_drop",  32'(DropCount),  32'd4);
        for (int i = 0; i < 15; i++) drain_exp[i] = 32'(i + 2);
        drain_exp[15] = 32'd100;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_valid%0d", i), 32'(TraceValid), 32'd1);
            check($sformatf("drain_data%0d", i),  TraceData,       drain_exp[i]);
            TraceReady = 1'b1;
            step();
        end
        TraceReady = 1'b0;
        check("drained_valid", 32'(TraceValid), 32'd0);
        check("drained_count", 32'(TraceCount), 32'd0);
        check("drained_ovf",   32'(Overflow),   32'd1);

        // drop saturation: 16 fill + 260 drops -> 4 + 260 saturates at 255
        for (int i = 0; i < 276; i++) begin
            commit(32'(i), 32'(i + 1000));
            step();
        end
        idle_inputs();
        check("sat_drop",  32'(DropCount),  32'd255);
        check("sat_count", 32'(TraceCount), 32'd16);
        check("sat_head",  TraceData,       32'd1000);

        // reset mid-drain: leave 5 entries, then reset during a pop
        TraceReady = 1'b1;
        for (int i = 0; i < 11; i++) step();
        check("mid_count", 32'(TraceCount), 32'd5);
        check("mid_head",  TraceData,       32'd1011);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        TraceReady = 1'b0;
        check("mrst_valid", 32'(TraceValid), 32'd0);
        check("mrst_count", 32'(TraceCount), 32'd0);
        check("mrst_ovf",   32'(Overflow),   32'd0);
        check("mrst_drop",  32'(DropCount),  32'd0);
        check("mrst_data",  TraceData,       32'd0);
        step();
        step();
        check("mrst_stay", 32'(TraceCount), 32'd0);

        // stamp wrap: reapply reset so the current cycle holds stamp 0
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int i = 0; i < 65535; i++) step();
        commit(32'h0000_1000, 32'h0000_00F1);
        ALUhi = 32'hDEAD_BEEF;
        ALUlo = 32'h0BAD_F00D;
        step();
        commit(32'h0000_1004, 32'h0000_00F2);
        ALUhi = 32'hDEAD_BEEF;
        ALUlo = 32'h1234_5678;
        step();
        idle_inputs();
        check("wrap_count",  32'(TraceCount), 32'd2);
        check("wrap_stamp0", 32'(TraceStamp), 32'h0000_FFFF);
        check("wrap_data0",  TraceData,       32'hF1);
        check("wrap_hi0",    TraceHi, HILO ? 32'hDEAD_BEEF : 32'd0);
        check("wrap_lo0",    TraceLo, HILO ? 32'h0BAD_F00D : 32'd0);
        TraceReady = 1'b1;
        step();
        TraceReady = 1'b0;
        check("wrap_stamp1", 32'(TraceStamp), 32'h0000_0000);
        check("wrap_pc1",    TracePC,         32'h1004);
        check("wrap_hi1",    TraceHi, HILO ? 32'hDEAD_BEEF : 32'd0);
        check("wrap_lo1",    TraceLo, HILO ? 32'h1234_5678 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
